// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared between the ALU-path shifters.
//   DATA_W      operand/result width (equals 2**SHAMT_W)
//   SHAMT_W     shift-amount width, also the number of binary shift stages
//   NUM_STAGES  cycles spent in RUN, one per binary stage
//   state_e     control state of the sequential shifters
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int NUM_STAGES = SHAMT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sll_stage.sv
// sll_stage: one combinational binary stage of the logical-left shifter.
//   in_i    value entering the stage
//   en_i    apply this stage's shift
//   k_i     stage index; stage k shifts by 2**(SHAMT_W-1-k)
//   out_o   shifted (or passed-through) value, zero-filled from the LSB
//   lost_o  1 when en_i and any 1-bit falls off the MSB end
module sll_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W,
  parameter int KW      = $clog2(SHAMT_W)
) (
  input  logic [DATA_W-1:0] in_i,
  input  logic              en_i,
  input  logic [KW-1:0]     k_i,
  output logic [DATA_W-1:0] out_o,
  output logic              lost_o
);

  logic [KW-1:0]     top_idx;
  logic [SHAMT_W:0]  size;
  logic [DATA_W-1:0] keep_mask;

  always_comb begin
    top_idx   = KW'(SHAMT_W - 1) - k_i;
    size      = {{SHAMT_W{1'b0}}, 1'b1} << top_idx;
    // Bits that survive the shift sit below the top 'size' positions.
    keep_mask = {DATA_W{1'b1}} >> size;
    out_o     = en_i ? (in_i << size) : in_i;
    lost_o    = en_i & (|(in_i & ~keep_mask));
  end

endmodule

// File: rtl/sll_shift_seq.sv
// sll_shift_seq: sequential logical-left shifter, one binary stage per cycle
// (largest stage first), fixed NUM_STAGES-cycle latency for every shift amount.
//   clock       rising-edge clock
//   reset       synchronous, active-high; aborts any operation in flight
//   start       request, sampled only while busy is low
//   operand     value to shift, captured when start is accepted
//   shamt       shift amount, captured when start is accepted
//   busy        operation in progress
//   result_rdy  one-cycle pulse marking result/bits_lost as fresh
//   result      shifted value, held until the next completion
//   bits_lost   1 if any 1-bit left the MSB end, held with result
module sll_shift_seq
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               result_rdy,
  output logic [DATA_W-1:0]  result,
  output logic               bits_lost
);

  localparam int KW = $clog2(SHAMT_W);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic               lost_q, lost_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               bits_lost_q, bits_lost_d;
  logic               rdy_q, rdy_d;

  logic [KW-1:0]      bit_idx;
  logic               stg_en;
  logic [DATA_W-1:0]  stg_out;
  logic               stg_lost;

  // The stage counter selects both the shift size and the amount bit,
  // so a single stage instance serves every cycle of the operation.
  assign bit_idx = KW'(SHAMT_W - 1) - cnt_q;
  assign stg_en  = amt_q[bit_idx];

  sll_stage #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
    .KW      (KW)
  ) u_stage (
    .in_i   (acc_q),
    .en_i   (stg_en),
    .k_i    (cnt_q),
    .out_o  (stg_out),
    .lost_o (stg_lost)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      amt_q       <= '0;
      cnt_q       <= '0;
      lost_q      <= 1'b0;
      result_q    <= '0;
      bits_lost_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      result_q    <= result_d;
      bits_lost_q <= bits_lost_d;
      rdy_q       <= rdy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    amt_d       = amt_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    result_d    = result_q;
    bits_lost_d = bits_lost_q;
    rdy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = operand;
          amt_d   = shamt;
          lost_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = stg_out;
        lost_d = lost_q | stg_lost;
        cnt_d  = cnt_q + KW'(1);
        // Last stage: publish the outcome and free the unit in the same edge,
        // so a new start can be accepted while result_rdy is high.
        if (cnt_q == KW'(NUM_STAGES - 1)) begin
          result_d    = stg_out;
          bits_lost_d = lost_q | stg_lost;
          rdy_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign result_rdy = rdy_q;
  assign result     = result_q;
  assign bits_lost  = bits_lost_q;

endmodule

// File: tb/tb_sll_shift_seq.sv
// tb_sll_shift_seq: directed and randomized bench for sll_shift_seq.
// Expected values come from a plain 64-bit arithmetic reference of a left shift.
module tb_sll_shift_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] operand = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        result_rdy;
  logic [31:0] result;
  logic        bits_lost;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_result = '0;
  logic        prev_lost = 1'b0;

  sll_shift_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .operand    (operand),
    .shamt      (shamt),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .bits_lost  (bits_lost)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] op, input logic [4:0] sh);
    logic [63:0] wide;
    wide = {32'b0, op} << sh;
    return wide[31:0];
  endfunction

  function automatic logic ref_lost(input logic [31:0] op, input logic [4:0] sh);
    logic [63:0] wide;
    wide = {32'b0, op} << sh;
    return |wide[63:32];
  endfunction

  // Called at a negedge with the unit idle (or with result_rdy high).
  // Returns at the negedge where result_rdy is seen (or after a bounded wait).
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input string tag);
    int cyc;
    operand = op;
    shamt   = sh;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    operand = $urandom;
    shamt   = 5'($urandom);
    cyc = 0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_held"}, result, prev_result);
    while (!result_rdy && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd5);
    check({tag, "_result"}, result, ref_result(op, sh));
    check({tag, "_lost"}, {31'b0, bits_lost}, {31'b0, ref_lost(op, sh)});
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    prev_result = ref_result(op, sh);
    prev_lost   = ref_lost(op, sh);
  endtask

  initial begin
    int pulses;
    int first_pulse;
    logic [31:0] seen_result;
    logic        seen_lost;
    logic [31:0] rop;
    logic [4:0]  rsh;

    // 1: reset, then idle
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdy", {31'b0, result_rdy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_lost", {31'b0, bits_lost}, 32'd0);

    // 2-4: directed shifts, including the boundary amounts
    run_op(32'h0000_0001, 5'd31, "t2");
    check("t2_const", result, 32'h8000_0000);
    @(negedge clock);
    check("t2_pulse_once", {31'b0, result_rdy}, 32'd0);
    check("t2_hold", result, 32'h8000_0000);
    run_op(32'hF000_000F, 5'd4, "t3");
    check("t3_const", result, 32'h0000_00F0);
    check("t3_lost_const", {31'b0, bits_lost}, 32'd1);
    @(negedge clock);
    run_op(32'h1234_5678, 5'd0, "t4");
    check("t4_const", result, 32'h1234_5678);
    @(negedge clock);

    // 5: a start while busy is ignored, not queued
    operand = 32'hA5A5_A5A5;
    shamt   = 5'd8;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    first_pulse = -1;
    seen_result = '0;
    seen_lost = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        operand = 32'd1;
        shamt   = 5'd1;
        start   = 1'b1;
      end
      @(negedge clock);
      start = 1'b0;
      if (result_rdy) begin
        pulses++;
        if (first_pulse < 0) begin
          first_pulse = c;
          seen_result = result;
          seen_lost   = bits_lost;
        end
      end
    end
    check("t5_pulses", pulses, 32'd1);
    check("t5_latency", first_pulse, 32'd5);
    check("t5_result", seen_result, 32'hA5A5_A500);
    check("t5_lost", {31'b0, seen_lost}, 32'd1);
    prev_result = 32'hA5A5_A500;
    prev_lost   = 1'b1;

    // 6: reset mid-operation aborts without a pulse
    operand = 32'hFF;
    shamt   = 5'd16;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_rdy", {31'b0, result_rdy}, 32'd0);
    check("t6_result", result, 32'd0);
    check("t6_lost", {31'b0, bits_lost}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (result_rdy) pulses++;
    end
    check("t6_no_pulse", pulses, 32'd0);
    prev_result = '0;
    prev_lost   = 1'b0;
    run_op(32'd3, 5'd2, "t6b");
    check("t6b_const", result, 32'hC);

    // 7: back-to-back, next start issued in the result_rdy cycle
    run_op(32'h0000_8001, 5'd17, "t7");

    // 8: random pairs, issued back-to-back
    for (int i = 0; i < 1000; i++) begin
      rop = $urandom;
      rsh = 5'($urandom_range(0, 31));
      if (i % 50 == 0) rsh = 5'd0;
      if (i % 50 == 1) rsh = 5'd31;
      run_op(rop, rsh, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
